cpu_run_ctrl: RTL

Parametrised run controller that sequences the MIPS core through reset, run and termination. It replaces the fixed-delay reset and fixed-time stop with synthesisable, cycle-accurate control. It sits between the top-level clock/reset and the `cpu` instance, and drives the core's active-high reset and clock enable. It counts run cycles and data-memory accesses (from `ram_enabler`), and terminates on halt request, cycle timeout or memory-inactivity hang, reporting the cause.

---
 rtl/cpu_run_ctrl_if.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the run controller and its host.
// The master side drives the run requests; the slave side is cpu_run_ctrl.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             abort;
    logic             halt_req;
    logic             mem_en;
    logic             cpu_rst;
    logic             cpu_clk_en;
    logic             running;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] mem_count;

    modport master (
        output start, abort, halt_req, mem_en,
        input  cpu_rst, cpu_clk_en, running, done, status, cycle_count, mem_count
    );

    modport slave (
        input  start, abort, halt_req, mem_en,
        output cpu_rst, cpu_clk_en, running, done, status, cycle_count, mem_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the MIPS core: reset hold, run, and termination on
// halt, cycle timeout or memory-inactivity hang, with cycle/access counters.
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES = 10,
    parameter int unsigned MAX_CYCLES = 5000,
    parameter int unsigned IDLE_LIMIT = 256,
    parameter int unsigned CNT_W      = 32
) (
    input logic          clk,
    input logic          rst,
    cpu_run_ctrl_if.slave bus
);
    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned IDLE_W = (IDLE_LIMIT > 0) ? $clog2(IDLE_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_HANG    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   mem_q, mem_d;
    logic [1:0]         status_q, status_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               clk_en_q, clk_en_d;
    logic               running_q, running_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   cyc_inc, mem_inc;
    logic [IDLE_W-1:0]  idle_inc;

    // Saturating increments; comparisons are done at 64 bits so a limit wider
    // than the counter can never alias to a smaller count.
    always_comb begin
        cyc_inc  = (cyc_q  == CNT_MAX)  ? cyc_q  : cyc_q  + CNT_W'(1);
        mem_inc  = (mem_q  == CNT_MAX)  ? mem_q  : mem_q  + CNT_W'(1);
        idle_inc = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        idle_d   = idle_q;
        cyc_d    = cyc_q;
        mem_d    = mem_q;
        status_d = status_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_HOLD;
                    hold_d   = '0;
                    idle_d   = '0;
                    cyc_d    = '0;
                    mem_d    = '0;
                    status_d = ST_NONE;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) state_d = S_RUN;
                else                     hold_d  = hold_q + HOLD_W'(1);
            end
            S_RUN: begin
                cyc_d  = cyc_inc;
                mem_d  = bus.mem_en ? mem_inc : mem_q;
                idle_d = bus.mem_en ? '0 : idle_inc;
                if (bus.halt_req) begin
                    state_d  = S_DONE;
                    status_d = ST_HALT;
                end else if (64'(cyc_inc) == 64'(MAX_CYCLES)) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else if (IDLE_LIMIT != 0 && !bus.mem_en &&
                             64'(idle_inc) == 64'(IDLE_LIMIT)) begin
                    state_d  = S_DONE;
                    status_d = ST_HANG;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything and freezes counters and status.
        if (bus.abort) begin
            state_d  = S_IDLE;
            hold_d   = hold_q;
            idle_d   = idle_q;
            cyc_d    = cyc_q;
            mem_d    = mem_q;
            status_d = status_q;
        end

        cpu_rst_d = (state_d == S_IDLE) || (state_d == S_HOLD);
        clk_en_d  = (state_d == S_RUN);
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            idle_q    <= '0;
            cyc_q     <= '0;
            mem_q     <= '0;
            status_q  <= ST_NONE;
            cpu_rst_q <= 1'b1;
            clk_en_q  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            idle_q    <= idle_d;
            cyc_q     <= cyc_d;
            mem_q     <= mem_d;
            status_q  <= status_d;
            cpu_rst_q <= cpu_rst_d;
            clk_en_q  <= clk_en_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.cpu_clk_en  = clk_en_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.status      = status_q;
    assign bus.cycle_count = cyc_q;
    assign bus.mem_count   = mem_q;
endmodule
